// File: rtl/pc_stack_if.sv
// Signal bundle between cpu_control/datapath (master) and the PC/return-address stack (slave).
interface pc_stack_if #(
  parameter int ADDR_W  = 12,
  parameter int WORD_W  = 4,
  parameter int DEPTH   = 3,
  parameter int CYCLE_W = 3
);
  localparam int NW   = ADDR_W / WORD_W;
  localparam int DU_W = $clog2(DEPTH + 1);

  logic               halt;
  logic [CYCLE_W-1:0] cycle;
  logic [1:0]         cmd;
  logic [ADDR_W-1:0]  target;
  logic [WORD_W-1:0]  data;
  logic [NW-1:0]      word_wr;
  logic               inc;
  logic [ADDR_W-1:0]  pc;
  logic [WORD_W-1:0]  pc_word;
  logic               pc_enable;
  logic [DU_W-1:0]    depth_used;
  logic               overflow;
  logic               underflow;

  modport master (
    output halt, cycle, cmd, target, data, word_wr, inc,
    input  pc, pc_word, pc_enable, depth_used, overflow, underflow
  );

  modport slave (
    input  halt, cycle, cmd, target, data, word_wr, inc,
    output pc, pc_word, pc_enable, depth_used, overflow, underflow
  );
endinterface

// File: rtl/pc_stack_param.sv
// Program counter plus DEPTH-level circular return-address stack, serialised onto the nibble bus.
// Define PC_STACK_ERR_EN to build the sticky overflow/underflow flags; otherwise they read as 0.
module pc_stack_param #(
  parameter int ADDR_W  = 12,
  parameter int WORD_W  = 4,
  parameter int DEPTH   = 3,
  parameter int CYCLE_W = 3
) (
  input logic         clock_i,
  input logic         reset_i,
  pc_stack_if.slave   bus
);
  localparam int NW    = ADDR_W / WORD_W;
  localparam int DU_W  = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_CALL = 2'b01,
    CMD_RET  = 2'b10,
    CMD_JUMP = 2'b11
  } cmd_e;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] lvl_q [DEPTH];
  logic [ADDR_W-1:0] lvl_d [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc_s, ptr_dec_s;
  logic [DU_W-1:0]   du_q, du_d;
  logic              full_s, empty_s;
  logic [WORD_W-1:0] pc_word_s;
  cmd_e              cmd_s;

  assign cmd_s     = cmd_e'(bus.cmd);
  assign full_s    = (du_q == DU_W'(DEPTH));
  assign empty_s   = (du_q == '0);
  // Write pointer walks 0..DEPTH-1 and wraps both ways, so a full stack overwrites its oldest entry.
  assign ptr_inc_s = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1'b1);
  assign ptr_dec_s = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1'b1);

  // Next-state: halt > cmd > word_wr > inc.
  always_comb begin
    pc_d  = pc_q;
    lvl_d = lvl_q;
    ptr_d = ptr_q;
    du_d  = du_q;
    if (!bus.halt) begin
      case (cmd_s)
        CMD_CALL: begin
          lvl_d[ptr_q] = pc_q + ADDR_W'(bus.inc);
          ptr_d        = ptr_inc_s;
          pc_d         = bus.target;
          du_d         = full_s ? du_q : du_q + DU_W'(1'b1);
        end
        CMD_RET: begin
          ptr_d = ptr_dec_s;
          pc_d  = lvl_q[ptr_dec_s];
          du_d  = empty_s ? du_q : du_q - DU_W'(1'b1);
        end
        CMD_JUMP: begin
          pc_d = bus.target;
        end
        default: begin
          if (|bus.word_wr) begin
            for (int i = 0; i < NW; i++) begin
              if (bus.word_wr[i]) begin
                pc_d[i*WORD_W +: WORD_W] = bus.data;
              end else begin
                pc_d[i*WORD_W +: WORD_W] = pc_q[i*WORD_W +: WORD_W];
              end
            end
          end else if (bus.inc) begin
            pc_d = pc_q + ADDR_W'(1'b1);
          end else begin
            pc_d = pc_q;
          end
        end
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q  <= '0;
      ptr_q <= '0;
      du_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        lvl_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      du_q  <= du_d;
      lvl_q <= lvl_d;
    end
  end

  // Nibble mux for the bus: cycle i carries pc bits [i*WORD_W +: WORD_W], zero outside the PC window.
  always_comb begin
    pc_word_s = '0;
    for (int i = 0; i < NW; i++) begin
      pc_word_s = pc_word_s |
                  ({WORD_W{bus.cycle == CYCLE_W'(i)}} & pc_q[i*WORD_W +: WORD_W]);
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_word    = pc_word_s;
  assign bus.pc_enable  = ({{(32-CYCLE_W){1'b0}}, bus.cycle} < 32'(NW));
  assign bus.depth_used = du_q;

`ifdef PC_STACK_ERR_EN
  logic ovf_q, unf_q;

  // Sticky misuse flags, cleared only by reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (!bus.halt && (cmd_s == CMD_CALL) && full_s);
      unf_q <= unf_q | (!bus.halt && (cmd_s == CMD_RET) && empty_s);
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack_param.sv
// Directed bench for pc_stack_param: a queue-free arithmetic model is checked every negedge,
// plus literal expectations taken from hand-worked scenarios.
module tb_pc_stack_param;
  localparam int ADDR_W  = 12;
  localparam int WORD_W  = 4;
  localparam int DEPTH   = 3;
  localparam int CYCLE_W = 3;
  localparam int NW      = ADDR_W / WORD_W;
  localparam int PC_MOD  = 1 << ADDR_W;
  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_CALL = 2'b01;
  localparam logic [1:0] C_RET  = 2'b10;
  localparam logic [1:0] C_JUMP = 2'b11;
`ifdef PC_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pc_stack_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .CYCLE_W(CYCLE_W)) bus ();

  pc_stack_param #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .CYCLE_W(CYCLE_W)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: plain integers, stack as a ring indexed modulo DEPTH.
  int m_pc;
  int m_lvl [DEPTH];
  int m_ptr;
  int m_du;
  bit m_ovf;
  bit m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_pc = 0; m_ptr = 0; m_du = 0; m_ovf = 1'b0; m_unf = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_lvl[i] = 0;
    end else if (!bus.halt) begin
      case (bus.cmd)
        C_CALL: begin
          m_lvl[m_ptr] = (m_pc + int'(bus.inc)) % PC_MOD;
          m_ptr = (m_ptr + 1) % DEPTH;
          m_pc  = int'(bus.target);
          if (m_du == DEPTH) m_ovf = 1'b1; else m_du++;
        end
        C_RET: begin
          m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
          m_pc  = m_lvl[m_ptr];
          if (m_du == 0) m_unf = 1'b1; else m_du--;
        end
        C_JUMP: m_pc = int'(bus.target);
        default: begin
          if (bus.word_wr != '0) begin
            for (int i = 0; i < NW; i++)
              if (bus.word_wr[i])
                m_pc = (m_pc & ~(15 << (4*i))) | (int'(bus.data) << (4*i));
          end else if (bus.inc) begin
            m_pc = (m_pc + 1) % PC_MOD;
          end
        end
      endcase
    end
  endtask

  // Compare process: every negedge once the model is initialised.
  always @(negedge clock) begin
    if (chk_en) begin
      int cyc;
      cyc = int'(bus.cycle);
      chk("pc", 32'(bus.pc), 32'(m_pc));
      chk("pc_enable", 32'(bus.pc_enable), (cyc < NW) ? 32'd1 : 32'd0);
      chk("pc_word", 32'(bus.pc_word), (cyc < NW) ? 32'((m_pc >> (WORD_W*cyc)) & 15) : 32'd0);
      chk("depth_used", 32'(bus.depth_used), 32'(m_du));
      chk("overflow", 32'(bus.overflow), ERR_EN ? 32'(m_ovf) : 32'd0);
      chk("underflow", 32'(bus.underflow), ERR_EN ? 32'(m_unf) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    model_update();
    bus.cycle = bus.cycle + 3'd1;
  endtask

  task automatic idle();
    bus.halt = 1'b0; bus.cmd = C_NONE; bus.target = '0;
    bus.data = '0; bus.word_wr = '0; bus.inc = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [11:0] tgt, input logic i);
    bus.cmd = c; bus.target = tgt; bus.inc = i;
    tick();
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  logic [11:0] ret_exp [4];

  initial begin
    idle();
    bus.cycle = '0;
    do_reset();
    do_reset();
    chk_en = 1'b1;
    chk("reset_pc", 32'(bus.pc), 32'h000);
    chk("reset_depth", 32'(bus.depth_used), 32'd0);

    // 1: five increments, then walk the bus cycles
    bus.inc = 1'b1;
    repeat (5) tick();
    bus.inc = 1'b0;
    chk("t1_pc", 32'(bus.pc), 32'h005);
    chk("t1_model", 32'(m_pc), 32'h005);
    bus.cycle = 3'd0; #1;
    chk("t1_w0", 32'(bus.pc_word), 32'h5); chk("t1_en0", 32'(bus.pc_enable), 32'd1);
    bus.cycle = 3'd1; #1;
    chk("t1_w1", 32'(bus.pc_word), 32'h0); chk("t1_en1", 32'(bus.pc_enable), 32'd1);
    bus.cycle = 3'd2; #1;
    chk("t1_w2", 32'(bus.pc_word), 32'h0); chk("t1_en2", 32'(bus.pc_enable), 32'd1);
    bus.cycle = 3'd3; #1;
    chk("t1_en3", 32'(bus.pc_enable), 32'd0);

    // 2: call with inc saves pc+1
    do_cmd(C_JUMP, 12'h123, 1'b0);
    chk("t2_jump", 32'(bus.pc), 32'h123);
    do_cmd(C_CALL, 12'h400, 1'b1);
    chk("t2_call_pc", 32'(bus.pc), 32'h400);
    chk("t2_call_du", 32'(bus.depth_used), 32'd1);
    do_cmd(C_RET, 12'h000, 1'b0);
    chk("t2_ret_pc", 32'(bus.pc), 32'h124);
    chk("t2_ret_du", 32'(bus.depth_used), 32'd0);

    // 3: overfill the stack, then drain past empty
    do_reset();
    do_cmd(C_JUMP, 12'h010, 1'b0);
    do_cmd(C_CALL, 12'h100, 1'b0);
    do_cmd(C_CALL, 12'h200, 1'b0);
    do_cmd(C_CALL, 12'h300, 1'b0);
    chk("t3_ovf_before", 32'(bus.overflow), 32'd0);
    do_cmd(C_CALL, 12'h400, 1'b0);
    chk("t3_pc", 32'(bus.pc), 32'h400);
    chk("t3_du", 32'(bus.depth_used), 32'd3);
    chk("t3_ovf", 32'(bus.overflow), 32'(ERR_EN));
    ret_exp[0] = 12'h300; ret_exp[1] = 12'h200; ret_exp[2] = 12'h100; ret_exp[3] = 12'h300;
    for (int k = 0; k < 4; k++) begin
      chk("t3_unf_pre", 32'(bus.underflow), 32'd0);
      do_cmd(C_RET, 12'h000, 1'b0);
      chk("t3_ret_pc", 32'(bus.pc), 32'(ret_exp[k]));
    end
    chk("t3_unf", 32'(bus.underflow), 32'(ERR_EN));
    chk("t3_du_end", 32'(bus.depth_used), 32'd0);

    // 4: wrap at top, nibble writes override inc
    do_reset();
    do_cmd(C_JUMP, 12'hFFF, 1'b0);
    bus.inc = 1'b1; tick(); idle();
    chk("t4_wrap", 32'(bus.pc), 32'h000);
    chk("t4_noflag", 32'({bus.overflow, bus.underflow}), 32'd0);
    bus.word_wr = 3'b101; bus.data = 4'hA; bus.inc = 1'b1; tick(); idle();
    chk("t4_ww", 32'(bus.pc), 32'hA0A);
    bus.word_wr = 3'b010; bus.data = 4'h5; tick(); idle();
    chk("t4_ww_mid", 32'(bus.pc), 32'hA5A);

    // 5: halt freezes everything
    do_cmd(C_JUMP, 12'h050, 1'b0);
    do_cmd(C_CALL, 12'h200, 1'b0);
    bus.halt = 1'b1; bus.cmd = C_CALL; bus.target = 12'h333; bus.inc = 1'b1; bus.word_wr = 3'b111;
    repeat (4) tick();
    chk("t5_pc", 32'(bus.pc), 32'h200);
    chk("t5_du", 32'(bus.depth_used), 32'd1);
    idle();
    do_cmd(C_RET, 12'h000, 1'b0);
    chk("t5_ret", 32'(bus.pc), 32'h050);

    // 6: reset beats a simultaneous return
    do_cmd(C_RET, 12'h000, 1'b0);
    chk("t6_unf", 32'(bus.underflow), 32'(ERR_EN));
    do_cmd(C_CALL, 12'h600, 1'b1);
    bus.cmd = C_RET; reset = 1'b1; tick(); reset = 1'b0; idle();
    chk("t6_pc", 32'(bus.pc), 32'h000);
    chk("t6_du", 32'(bus.depth_used), 32'd0);
    chk("t6_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
